// File: rtl/move_scheduler_if.sv
// move_scheduler_if: button/status inputs and move/status outputs of the move scheduler.
interface move_scheduler_if;
  localparam int unsigned COUNT_W = 8;

  logic               btn_n;
  logic               btn_s;
  logic               btn_e;
  logic               btn_w;
  logic               dead;
  logic               win;
  logic               N;
  logic               S;
  logic               E;
  logic               W;
  logic               busy;
  logic               game_over;
  logic [COUNT_W-1:0] move_count;

  // Driver side: buttons and location-FSM status in, moves and status out.
  modport master (
    output btn_n, btn_s, btn_e, btn_w, dead, win,
    input  N, S, E, W, busy, game_over, move_count
  );

  // Scheduler side.
  modport slave (
    input  btn_n, btn_s, btn_e, btn_w, dead, win,
    output N, S, E, W, busy, game_over, move_count
  );
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: debounces four direction buttons and issues spaced, one-hot
// move pulses to the location FSM until it reports death or win.
module move_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic            clock,
  input  logic            reset,
  move_scheduler_if.slave bus
);
  localparam int unsigned NB  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned I_N = 0;
  localparam int unsigned I_S = 1;
  localparam int unsigned I_E = 2;
  localparam int unsigned I_W = 3;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  logic [NB-1:0]         raw;
  logic [NB-1:0]         sync1_q, sync1_d;
  logic [NB-1:0]         sync2_q, sync2_d;
  logic [NB-1:0]         deb_q, deb_d;
  logic [NB-1:0]         deb_prev_q, deb_prev_d;
  logic [NB-1:0][CW-1:0] stab_q, stab_d;
  logic [NB-1:0]         press;

  logic [1:0]            state_q, state_d;
  logic [NB-1:0]         dir_q, dir_d;
  logic [CW-1:0]         gap_q, gap_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  over_q, over_d;
  logic                  end_game;

  assign raw      = {bus.btn_w, bus.btn_e, bus.btn_s, bus.btn_n};
  assign end_game = bus.dead | bus.win;
  assign press    = deb_q & ~deb_prev_q;

  // Synchronize, then debounce: a level change needs DEBOUNCE_CYCLES disagreeing samples in a row.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    stab_d     = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (stab_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Scheduler next state; status outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    dir_d   = '0;
    gap_d   = gap_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (end_game) begin
          state_d = ST_OVER;
        end else if (|press) begin
          state_d = ST_ISSUE;
          if (press[I_N]) begin
            dir_d[I_N] = 1'b1;
          end else if (press[I_E]) begin
            dir_d[I_E] = 1'b1;
          end else if (press[I_S]) begin
            dir_d[I_S] = 1'b1;
          end else begin
            dir_d[I_W] = 1'b1;
          end
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      ST_ISSUE: begin
        if (end_game) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (end_game) begin
          state_d = ST_OVER;
        end else if (gap_q == CNT_ONE) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - CNT_ONE;
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_GAP);
    over_d = (state_d == ST_OVER);
  end

  // All state, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      stab_q     <= '0;
      state_q    <= ST_IDLE;
      dir_q      <= '0;
      gap_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      stab_q     <= stab_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      gap_q      <= gap_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      over_q     <= over_d;
    end
  end

  assign bus.N          = dir_q[I_N];
  assign bus.S          = dir_q[I_S];
  assign bus.E          = dir_q[I_E];
  assign bus.W          = dir_q[I_W];
  assign bus.busy       = busy_q;
  assign bus.game_over  = over_q;
  assign bus.move_count = count_q;
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: scoreboard bench; a run-length button model predicts move pulses.
module tb_move_scheduler;
  localparam int D   = 4;
  localparam int G   = 2;
  localparam int BIG = 32'h7fffffff;

  typedef struct {
    int         ev_edge;
    logic [3:0] dir;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  move_scheduler_if bus();

  move_scheduler #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state. Bit order of all masks: 0=N 1=S 2=E 3=W.
  exp_t       exp_q[$];
  int         issued_q[$];
  logic [3:0] lvl;
  logic [3:0] mdeb;
  int         run_start [4];
  int         ready_edge;
  int         over_edge;
  int         last_issue;
  int         mcount;
  bit         arm_over;
  bit         arm_dead;
  int         arm_off;
  bit         mon_en = 1'b0;
  logic [3:0] mon_p;
  logic [3:0] exp_p;
  exp_t       mon_it;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] pick(input logic [3:0] r);
    if (r[0]) return 4'b0001;
    if (r[2]) return 4'b0100;
    if (r[1]) return 4'b0010;
    return 4'b1000;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    issued_q.delete();
    lvl        = '0;
    mdeb       = '0;
    for (int i = 0; i < 4; i++) run_start[i] = cyc;
    ready_edge = 0;
    over_edge  = BIG;
    last_issue = 0;
    mcount     = 0;
    arm_over   = 1'b0;
    arm_dead   = 1'b0;
    arm_off    = 0;
  endfunction

  // A button's debounced level flips once its raw level has held D samples;
  // a rise sampled first at edge s is seen by the scheduler at edge s+D+2.
  function automatic void model_eval(input int ke);
    logic [3:0] rise;
    int e;
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      if (lvl[i] != mdeb[i] && ke - run_start[i] + 1 >= D) begin
        mdeb[i] = lvl[i];
        rise[i] = lvl[i];
      end
    end
    if (rise != 4'b0000) begin
      e = ke + 3;
      if (e >= ready_edge && e < over_edge) begin
        exp_q.push_back('{ev_edge: e, dir: pick(rise)});
        issued_q.push_back(e);
        ready_edge = e + G + 2;
        last_issue = e;
        if (mcount < 255) mcount++;
      end
    end
  endfunction

  // Drive the raw level seen at the next rising edge k.
  task automatic tick(input logic [3:0] m);
    int k;
    @(negedge clock);
    k = cyc + 1;
    if (arm_over) begin
      over_edge = k + D + 2 + arm_off;
      arm_over  = 1'b0;
    end
    if (k == over_edge) begin
      if (arm_dead) bus.dead = 1'b1;
      else          bus.win  = 1'b1;
    end
    for (int i = 0; i < 4; i++) if (m[i] != lvl[i]) run_start[i] = k;
    lvl = m;
    {bus.btn_w, bus.btn_e, bus.btn_s, bus.btn_n} = m;
    model_eval(k);
  endtask

  task automatic set_level(input logic [3:0] m, input int n);
    for (int j = 0; j < n; j++) tick(m);
  endtask

  task automatic check_count(input string name);
    for (int j = 0; j < 40 && cyc < last_issue + 2; j++) tick(lvl);
    chk(name, int'(bus.move_count), mcount);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_N"}, int'(bus.N), 0);
    chk({tag, "_S"}, int'(bus.S), 0);
    chk({tag, "_E"}, int'(bus.E), 0);
    chk({tag, "_W"}, int'(bus.W), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_game_over"}, int'(bus.game_over), 0);
    chk({tag, "_move_count"}, int'(bus.move_count), 0);
  endtask

  task automatic enter_reset();
    mon_en    = 1'b0;
    reset     = 1'b0;
    bus.btn_n = 1'b0;
    bus.btn_s = 1'b0;
    bus.btn_e = 1'b0;
    bus.btn_w = 1'b0;
    bus.dead  = 1'b0;
    bus.win   = 1'b0;
  endtask

  task automatic leave_reset();
    repeat (2) @(negedge clock);
    model_reset();
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares pulses, busy and game_over every cycle against the model.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mon_en) begin
        exp_p = '0;
        if (exp_q.size() > 0 && exp_q[0].ev_edge == cyc) begin
          mon_it = exp_q.pop_front();
          exp_p  = mon_it.dir;
        end
        mon_p = {bus.W, bus.E, bus.S, bus.N};
        chk("move_pulse", int'(mon_p), int'(exp_p));
        while (issued_q.size() > 0 && issued_q[0] + G < cyc) void'(issued_q.pop_front());
        chk("busy", int'(bus.busy),
            (issued_q.size() > 0 && issued_q[0] <= cyc && cyc < over_edge) ? 1 : 0);
        chk("game_over", int'(bus.game_over), (cyc >= over_edge) ? 1 : 0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    model_reset();
    enter_reset();
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    leave_reset();

    // Single clean press, held long: one N pulse only.
    set_level(4'b0001, 12);
    set_level(4'b0000, 8);
    check_count("count_first_press");

    // Bouncing E never stable for D samples, then a clean hold.
    set_level(4'b0100, 2);
    set_level(4'b0000, 1);
    set_level(4'b0100, 2);
    set_level(4'b0000, 1);
    set_level(4'b0100, 6);
    set_level(4'b0000, 8);
    check_count("count_after_bounce");

    // E and W together: E wins; W alone afterwards.
    set_level(4'b1100, 8);
    set_level(4'b0000, 8);
    set_level(4'b1000, 8);
    set_level(4'b0000, 8);
    check_count("count_after_ew");

    // S event lands in GAP while N is held: discarded even though S stays held.
    set_level(4'b0001, 2);
    set_level(4'b0011, 12);
    set_level(4'b0000, 10);
    check_count("count_after_gap_press");

    // Random levels and glitches of arbitrary length.
    for (int s = 0; s < 200; s++) begin
      set_level(4'($urandom_range(0, 15)), int'($urandom_range(1, D + 4)));
    end
    set_level(4'b0000, D + 4);
    check_count("count_after_random");

    // Clean random presses until the counter saturates.
    for (int p = 0; p < 260; p++) begin
      set_level(4'($urandom_range(1, 15)), D + int'($urandom_range(1, 4)));
      set_level(4'b0000, D + int'($urandom_range(2, 5)));
    end
    check_count("count_saturated");

    // Reset asserted mid-GAP clears outputs at once.
    set_level(4'b0001, D + 1);
    for (int j = 0; j < 20 && cyc != last_issue + 1; j++) tick(lvl);
    chk("busy_before_reset", int'(bus.busy), 1);
    mon_en = 1'b0;
    #2;
    enter_reset();
    #1;
    check_all_zero("reset_in_gap");
    leave_reset();
    set_level(4'b0001, D + 2);
    set_level(4'b0000, D + 3);
    check_count("count_after_gap_reset");

    // dead during ISSUE: pulse still issued, then OVER.
    arm_over = 1'b1;
    arm_dead = 1'b1;
    arm_off  = 1;
    set_level(4'b0001, D + 4);
    set_level(4'b0000, D + 3);
    set_level(4'b0100, D + 4);
    set_level(4'b0000, D + 3);
    check_count("count_after_dead");
    enter_reset();
    #1;
    check_all_zero("reset_after_dead");
    leave_reset();

    // win together with an N event in IDLE: no pulse, OVER absorbs later presses.
    arm_over = 1'b1;
    arm_dead = 1'b0;
    arm_off  = 0;
    set_level(4'b0001, D + 4);
    set_level(4'b0000, D + 3);
    set_level(4'b0010, D + 4);
    set_level(4'b0000, D + 3);
    set_level(4'b1000, D + 4);
    set_level(4'b0000, D + 6);
    chk("count_after_win", int'(bus.move_count), mcount);
    chk("pending_moves", exp_q.size(), 0);
    enter_reset();
    #1;
    chk("game_over_cleared", int'(bus.game_over), 0);
    chk("count_cleared", int'(bus.move_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
